// File: rtl/rs_codec_arbiter.sv
// rs_codec_arbiter: round-robin arbiter sharing one RS codec core between NUM_REQ frame sources.
// Define RS_ARB_TIMEOUT_EN to build the WAIT_DONE watchdog (timeout_err); otherwise timeout_err is tied low.
module rs_codec_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int FRAME_WIDTH    = 1600,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int ID_WIDTH       = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [NUM_REQ*FRAME_WIDTH-1:0] req_data_in,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [FRAME_WIDTH-1:0]         codec_data_out,
  output logic                           codec_start,
  input  logic                           codec_done,
  output logic [ID_WIDTH-1:0]            codec_src_id,
  output logic                           arb_busy,
  output logic [31:0]                    frames_issued,
  output logic                           timeout_err
);

  typedef enum logic [1:0] {IDLE, START, WAIT_DONE} state_t;

  state_t                 state;
  logic [ID_WIDTH-1:0]    rr_ptr;
  logic                   found;
  logic [ID_WIDTH-1:0]    winner;
  logic [ID_WIDTH-1:0]    search_idx;
  logic [FRAME_WIDTH-1:0] win_frame;
  logic [ID_WIDTH-1:0]    next_ptr;
  logic                   start_ok;
  logic                   expire;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("rs_codec_arbiter: parameter out of range");
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    found      = 1'b0;
    winner     = '0;
    search_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      search_idx = ID_WIDTH'((int'(rr_ptr) + k) % NUM_REQ);
      if (!found && req_valid[search_idx]) begin
        found  = 1'b1;
        winner = search_idx;
      end
    end
  end

  always_comb begin
    win_frame = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (ID_WIDTH'(k) == winner) win_frame = req_data_in[k*FRAME_WIDTH +: FRAME_WIDTH];
    end
  end

  assign next_ptr = (codec_src_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : codec_src_id + ID_WIDTH'(1);

  // The accept handshake is qualified by the live valid so a source that withdraws in START is never consumed.
  assign start_ok    = (state == START) && req_valid[codec_src_id];
  assign codec_start = start_ok;
  assign arb_busy    = (state != IDLE);

  always_comb begin
    req_ready = '0;
    if (start_ok) req_ready[codec_src_id] = 1'b1;
  end

`ifdef RS_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;

  assign expire = (state == WAIT_DONE) && !codec_done && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      wait_cnt <= (state == WAIT_DONE) ? wait_cnt + CNT_W'(1) : '0;
      if (expire) timeout_err <= 1'b1;
    end
  end
`else
  assign expire      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state          <= IDLE;
      rr_ptr         <= '0;
      codec_data_out <= '0;
      codec_src_id   <= '0;
      frames_issued  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            codec_data_out <= win_frame;
            codec_src_id   <= winner;
            state          <= START;
          end
        end
        START: begin
          if (start_ok) begin
            frames_issued <= frames_issued + 32'd1;
            state         <= WAIT_DONE;
          end else begin
            state <= IDLE;
          end
        end
        WAIT_DONE: begin
          if (codec_done || expire) begin
            rr_ptr <= next_ptr;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rs_codec_arbiter.sv
// tb_rs_codec_arbiter: directed and randomized checks of rs_codec_arbiter against a cycle-level reference model.
`timescale 1ns/1ps
module tb_rs_codec_arbiter;

  localparam int NR = 4;
  localparam int FW = 64;
  localparam int TO = 16;
  localparam int IW = 2;

  logic             clk = 1'b0;
  logic             rstn;
  logic [NR*FW-1:0] req_data_in;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [FW-1:0]    codec_data_out;
  logic             codec_start;
  logic             codec_done;
  logic [IW-1:0]    codec_src_id;
  logic             arb_busy;
  logic [31:0]      frames_issued;
  logic             timeout_err;

  always #5 clk = ~clk;

  rs_codec_arbiter #(
    .NUM_REQ(NR), .FRAME_WIDTH(FW), .TIMEOUT_CYCLES(TO), .ID_WIDTH(IW)
  ) dut (
    .clk(clk), .rstn(rstn), .req_data_in(req_data_in), .req_valid(req_valid),
    .req_ready(req_ready), .codec_data_out(codec_data_out), .codec_start(codec_start),
    .codec_done(codec_done), .codec_src_id(codec_src_id), .arb_busy(arb_busy),
    .frames_issued(frames_issued), .timeout_err(timeout_err)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: phase 0 = no owner, 1 = owner chosen awaiting handshake, 2 = codec busy.
  int          m_phase, m_rr, m_src, m_wait;
  logic [63:0] m_frame;
  int unsigned m_issued;
  bit          m_terr;
  int          cyc = 0;
  logic        obs_start;
  logic [NR-1:0] obs_ready;
  logic [IW-1:0] obs_id;
  logic [FW-1:0] obs_data;

  task automatic model_reset();
    m_phase = 0; m_rr = 0; m_src = 0; m_wait = 0;
    m_frame = '0; m_issued = 0; m_terr = 0;
  endtask

  task automatic randomize_data();
    for (int i = 0; i < NR; i++) req_data_in[i*FW +: FW] = {$urandom, $urandom};
  endtask

  task automatic cycle(input logic [NR-1:0] v, input logic d, input logic r);
    bit            exp_start;
    logic [NR-1:0] exp_ready;
    req_valid  = v;
    codec_done = d;
    rstn       = r;
    @(negedge clk);
    exp_start = (m_phase == 1) && v[m_src];
    exp_ready = exp_start ? (NR'(1) << m_src) : '0;
    check("codec_start",   codec_start,    exp_start);
    check("req_ready",     req_ready,      exp_ready);
    check("arb_busy",      arb_busy,       m_phase != 0);
    check("codec_data",    codec_data_out, m_frame);
    check("codec_src_id",  codec_src_id,   m_src);
    check("frames_issued", frames_issued,  m_issued);
    check("timeout_err",   timeout_err,    m_terr);
    obs_start = codec_start;
    obs_ready = req_ready;
    obs_id    = codec_src_id;
    obs_data  = codec_data_out;
    if (!r) begin
      model_reset();
    end else begin
      case (m_phase)
        0: begin
          for (int k = 0; k < NR; k++) begin
            int i;
            i = (m_rr + k) % NR;
            if (v[i]) begin
              m_src   = i;
              m_frame = req_data_in[i*FW +: FW];
              m_phase = 1;
              break;
            end
          end
        end
        1: begin
          if (v[m_src]) begin
            m_issued++;
            m_phase = 2;
            m_wait  = 0;
          end else begin
            m_phase = 0;
          end
        end
        default: begin
          if (d) begin
            m_rr    = (m_src + 1) % NR;
            m_phase = 0;
          end
`ifdef RS_ARB_TIMEOUT_EN
          else if (m_wait == TO - 1) begin
            m_terr  = 1;
            m_rr    = (m_src + 1) % NR;
            m_phase = 0;
          end else begin
            m_wait++;
          end
`endif
        end
      endcase
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  int   grants[$];
  int   exp_order[6] = '{0, 1, 2, 3, 0, 1};
  int   dones;
  int   start_cyc;
  logic dd;

  initial begin
    rstn        = 1'b0;
    req_valid   = '0;
    codec_done  = 1'b0;
    req_data_in = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    model_reset();

    // Reset values
    cycle('0, 1'b0, 1'b0);

    // Single source 2 with an 0xA5 frame, done ten cycles after start
    randomize_data();
    req_data_in[2*FW +: FW] = {8{8'hA5}};
    cycle(4'b0100, 1'b0, 1'b1);
    cycle(4'b0100, 1'b0, 1'b1);
    check("ss_start", obs_start, 1'b1);
    check("ss_ready", obs_ready, 4'b0100);
    check("ss_id",    obs_id,    2);
    check("ss_data",  obs_data,  {8{8'hA5}});
    for (int i = 1; i <= 10; i++) cycle('0, i == 10, 1'b1);
    cycle('0, 1'b0, 1'b1);
    check("ss_issued", frames_issued, 1);
    check("ss_idle",   arb_busy,      1'b0);

    // Round robin with all sources valid, done five cycles after each start
    cycle('0, 1'b0, 1'b0);
    dones     = 0;
    start_cyc = -100;
    for (int n = 0; n < 200 && dones < 6; n++) begin
      randomize_data();
      dd = (cyc == start_cyc + 5);
      cycle(4'hF, dd, 1'b1);
      if (dd) dones++;
      if (obs_start) begin
        grants.push_back(int'(obs_id));
        start_cyc = cyc - 1;
      end
    end
    check("rr_dones", dones, 6);
    check("rr_count", grants.size(), 6);
    for (int i = 0; i < 6 && i < grants.size(); i++) check("rr_grant", grants[i], exp_order[i]);
    cycle('0, 1'b0, 1'b1);
    check("rr_issued", frames_issued, 6);

    // Abort: source 1 withdraws in START, pointer must stay at 0
    cycle('0, 1'b0, 1'b0);
    randomize_data();
    cycle(4'b0010, 1'b0, 1'b1);
    cycle(4'b0000, 1'b0, 1'b1);
    check("ab_nostart", obs_start, 1'b0);
    cycle(4'b0000, 1'b0, 1'b1);
    cycle(4'b1010, 1'b0, 1'b1);
    cycle(4'b1010, 1'b0, 1'b1);
    check("ab_regrant", obs_id, 1);
    check("ab_start",   obs_start, 1'b1);
    cycle(4'b1000, 1'b1, 1'b1);

    // Spurious done in IDLE and START is ignored
    cycle('0, 1'b0, 1'b0);
    cycle('0, 1'b1, 1'b1);
    cycle(4'b1000, 1'b0, 1'b1);
    cycle(4'b1000, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cycle('0, 1'b0, 1'b1);
    check("sp_busy", arb_busy, 1'b1);
    cycle('0, 1'b1, 1'b1);
    cycle('0, 1'b0, 1'b1);
    check("sp_idle", arb_busy, 1'b0);
    cycle(4'b1001, 1'b0, 1'b1);
    cycle(4'b1001, 1'b0, 1'b1);
    check("sp_wrap", obs_id, 0);
    cycle('0, 1'b1, 1'b1);

    // Reset in the middle of WAIT_DONE
    cycle('0, 1'b0, 1'b0);
    cycle(4'b0001, 1'b0, 1'b1);
    cycle(4'b0001, 1'b0, 1'b1);
    cycle('0, 1'b0, 1'b1);
    cycle('0, 1'b0, 1'b0);
    check("rst_issued", frames_issued, 0);
    check("rst_busy",   arb_busy,      1'b0);
    cycle('0, 1'b0, 1'b1);

`ifdef RS_ARB_TIMEOUT_EN
    // Done on the expiry cycle is a normal completion
    cycle('0, 1'b0, 1'b0);
    cycle(4'b0001, 1'b0, 1'b1);
    cycle(4'b0001, 1'b0, 1'b1);
    for (int i = 1; i <= TO; i++) cycle('0, i == TO, 1'b1);
    check("to_edge_err",  timeout_err, 1'b0);
    check("to_edge_idle", arb_busy,    1'b0);

    // Watchdog expiry with no done, then the next source is served
    cycle('0, 1'b0, 1'b0);
    cycle(4'b1001, 1'b0, 1'b1);
    cycle(4'b1001, 1'b0, 1'b1);
    for (int i = 0; i < TO; i++) cycle(4'b1000, 1'b0, 1'b1);
    check("to_err",  timeout_err, 1'b1);
    check("to_idle", arb_busy,    1'b0);
    cycle(4'b1000, 1'b0, 1'b1);
    cycle(4'b1000, 1'b0, 1'b1);
    check("to_next", obs_id, 3);
    cycle('0, 1'b1, 1'b1);
`else
    // Without the watchdog the arbiter waits indefinitely
    cycle('0, 1'b0, 1'b0);
    cycle(4'b0001, 1'b0, 1'b1);
    cycle(4'b0001, 1'b0, 1'b1);
    for (int i = 0; i < 100; i++) cycle('0, 1'b0, 1'b1);
    check("nto_busy", arb_busy,    1'b1);
    check("nto_err",  timeout_err, 1'b0);
    cycle('0, 1'b1, 1'b1);
`endif

    // Randomized traffic with occasional resets
    cycle('0, 1'b0, 1'b0);
    for (int n = 0; n < 3000; n++) begin
      randomize_data();
      cycle(NR'($urandom), $urandom_range(0, 5) == 0, $urandom_range(0, 199) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
